aes_word_loader: RTL

//  Stream front/back end for the AES-128 encryption block.
//  - Packs four 32-bit input words into one 128-bit plaintext block and drives it on the encryption block's inputData.
//  - Issues the one-cycle encryptEnable pulse, then waits a fixed latency.
//  - Captures the 128-bit ciphertext and unpacks it into four 32-bit output words.
//  - Valid/ready handshakes on both word streams.

---
 rtl/aes_word_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/aes_word_loader.sv
// rtl/aes_word_loader.sv - word-stream packer/unpacker around an AES-128 encryption block
//
// Collects four 32-bit plaintext words into a 128-bit block, pulses the
// encryption block's start input, waits a fixed number of cycles, captures
// the 128-bit ciphertext and returns it as four 32-bit words. Word 0 is
// the most significant word on both sides. Only one block is in flight;
// new input is refused until the previous ciphertext has fully drained.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   in_data        plaintext word
//   in_valid       in_data valid
//   in_ready       word accepted when in_valid & in_ready
//   block_data     assembled plaintext, held stable from start pulse until drain completes
//   encrypt_enable one-cycle start pulse to the encryption block
//   enc_result     ciphertext from the encryption block
//   out_data       ciphertext word
//   out_valid      out_data valid
//   out_ready      downstream accepts out_data
//   blk_cnt        (only with AES_LOADER_CNT_EN) number of blocks fully drained, wraps
//
// Optional build macro: AES_LOADER_CNT_EN adds the blk_cnt output and its counter.

module aes_word_loader #(
    parameter int ENC_LATENCY = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] block_data,
    output logic         encrypt_enable,
    input  logic [127:0] enc_result,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef AES_LOADER_CNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'(ENC_LATENCY - 1);

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   in_idx;
    logic [1:0]   out_idx;
    logic [7:0]   lat_cnt;
    logic [127:0] block_q;
    logic [127:0] shift_q;
    logic         in_fire;
    logic         out_fire;
    logic         lat_done;

    assign block_data = block_q;
    assign out_data   = shift_q[127:96];
    assign lat_done   = (lat_cnt == LAT_LAST);

    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        encrypt_enable = 1'b0;
        out_valid      = 1'b0;
        in_fire        = 1'b0;
        out_fire       = 1'b0;
        case (state_q)
            FILL: begin
                // Gated by rst so in_ready stays low for the whole reset
                // and rises only in the first cycle after release.
                in_ready = !rst;
                in_fire  = in_valid && !rst;
                if (in_fire && in_idx == 2'd3) begin
                    state_d = START;
                end
            end
            START: begin
                encrypt_enable = 1'b1;
                state_d        = WAIT;
            end
            WAIT: begin
                if (lat_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_fire  = out_ready;
                if (out_fire && out_idx == 2'd3) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            in_idx  <= 2'd0;
            out_idx <= 2'd0;
            lat_cnt <= 8'd0;
            block_q <= 128'd0;
            shift_q <= 128'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FILL: begin
                    if (in_fire) begin
                        case (in_idx)
                            2'd0:    block_q[127:96] <= in_data;
                            2'd1:    block_q[95:64]  <= in_data;
                            2'd2:    block_q[63:32]  <= in_data;
                            default: block_q[31:0]   <= in_data;
                        endcase
                        in_idx <= in_idx + 2'd1;
                    end
                end
                START: begin
                    lat_cnt <= 8'd0;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_done) begin
                        shift_q <= enc_result;
                    end
                end
                DRAIN: begin
                    // After four shifts the register is all zero, so
                    // out_data reads 0 outside DRAIN without extra logic.
                    if (out_fire) begin
                        shift_q <= {shift_q[95:0], 32'd0};
                        out_idx <= out_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AES_LOADER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= 16'd0;
        end else if (out_fire && out_idx == 2'd3) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule
